// File: rtl/wts_envelope_pkg.sv
// Shared definitions for the envelope channel sequencer slice.
// Contents: envelope state encodings, CPU key command codes, context field
// widths and the packed per-channel context record.
package wts_envelope_pkg;

  localparam int CNT_W    = 20;
  localparam int LVL_W    = 7;
  localparam int ST_W     = 3;
  localparam int CTX_W    = CNT_W + ST_W + LVL_W;
  localparam int LVL_FULL = 64;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } eg_state_e;

  typedef enum logic [1:0] {
    KEY_NONE    = 2'd0,
    KEY_ON      = 2'd1,
    KEY_RELEASE = 2'd2,
    KEY_OFF     = 2'd3
  } key_cmd_e;

  // State is kept as raw bits: the datapath owns its meaning and the
  // sequencer stores whatever comes back.
  typedef struct packed {
    logic [CNT_W-1:0] counter;
    logic [ST_W-1:0]  state;
    logic [LVL_W-1:0] level;
  } eg_ctx_t;

endpackage

// File: rtl/wts_envelope_channel_sequencer_if.sv
// Signal bundle between the channel sequencer and its surroundings
// (CPU key port, envelope datapath, mixer level publish).
// Modports:
//   master - the sequencer: takes active/key commands/datapath results,
//            drives slot context, key pulses, slot_ch and published level.
//   slave  - the environment side (CPU, datapath, mixer).
interface wts_envelope_channel_sequencer_if #(
  parameter int CH_BITS = 3
);
  import wts_envelope_pkg::*;

  logic               active;
  logic               key_wr;
  logic [CH_BITS-1:0] key_ch;
  logic [1:0]         key_cmd;

  logic               eg_key_on;
  logic               eg_key_release;
  logic               eg_key_off;
  logic [CNT_W-1:0]   eg_counter_in;
  logic [ST_W-1:0]    eg_state_in;
  logic [LVL_W-1:0]   eg_level_in;
  logic [CNT_W-1:0]   eg_counter_out;
  logic [ST_W-1:0]    eg_state_out;
  logic [LVL_W-1:0]   eg_level_out;

  logic [CH_BITS-1:0] slot_ch;
  logic               env_valid;
  logic [CH_BITS-1:0] env_ch;
  logic [LVL_W-1:0]   env_level;

  modport master (
    input  active, key_wr, key_ch, key_cmd,
    input  eg_counter_out, eg_state_out, eg_level_out,
    output eg_key_on, eg_key_release, eg_key_off,
    output eg_counter_in, eg_state_in, eg_level_in,
    output slot_ch, env_valid, env_ch, env_level
  );

  modport slave (
    output active, key_wr, key_ch, key_cmd,
    output eg_counter_out, eg_state_out, eg_level_out,
    input  eg_key_on, eg_key_release, eg_key_off,
    input  eg_counter_in, eg_state_in, eg_level_in,
    input  slot_ch, env_valid, env_ch, env_level
  );

endinterface

// File: rtl/wts_envelope_context_ram.sv
// Per-channel envelope context store: CHANNELS entries of CTX_W bits,
// one asynchronous read port and one synchronous write port, cleared on reset.
// Ports: clk, nreset, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read).
module wts_envelope_context_ram
  import wts_envelope_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CH_BITS  = 3
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               wr_en,
  input  logic [CH_BITS-1:0] wr_addr,
  input  logic [CTX_W-1:0]   wr_data,
  input  logic [CH_BITS-1:0] rd_addr,
  output logic [CTX_W-1:0]   rd_data
);

  logic [CTX_W-1:0] mem [CHANNELS];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < CHANNELS)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < CHANNELS) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/wts_envelope_channel_sequencer.sv
// Time-multiplexed front/back end for the per-channel ADSR envelope datapath.
// Scans channels round-robin on active cycles, presents the slot channel's
// stored context and pending key command, writes the datapath result back and
// publishes the new level one cycle later.
// Ports: clk, nreset (async active-low), bus (master side of the sequencer
// interface: key port, datapath in/out, slot_ch, env publish).
module wts_envelope_channel_sequencer
  import wts_envelope_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CH_BITS  = 3
) (
  input  logic clk,
  input  logic nreset,
  wts_envelope_channel_sequencer_if.master bus
);

  if ((2 ** CH_BITS) < CHANNELS) begin : g_bad_width
    $error("CH_BITS too narrow for CHANNELS");
  end

  logic [CH_BITS-1:0] slot_ch;
  key_cmd_e           pending [CHANNELS];
  key_cmd_e           slot_pend;
  eg_ctx_t            rd_ctx;
  eg_ctx_t            wr_ctx;

  assign wr_ctx = '{counter: bus.eg_counter_out,
                    state:   bus.eg_state_out,
                    level:   bus.eg_level_out};

  wts_envelope_context_ram #(
    .CHANNELS (CHANNELS),
    .CH_BITS  (CH_BITS)
  ) u_ctx_ram (
    .clk     (clk),
    .nreset  (nreset),
    .wr_en   (bus.active),
    .wr_addr (slot_ch),
    .wr_data (wr_ctx),
    .rd_addr (slot_ch),
    .rd_data (rd_ctx)
  );

  // A CPU write to the slot being processed takes priority over the slot's
  // clear, so a colliding command is carried to the next visit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) pending[i] <= KEY_NONE;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.key_wr && (bus.key_ch == CH_BITS'(i)))
          pending[i] <= key_cmd_e'(bus.key_cmd);
        else if (bus.active && (slot_ch == CH_BITS'(i)))
          pending[i] <= KEY_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_ch       <= '0;
      bus.env_valid <= 1'b0;
      bus.env_ch    <= '0;
      bus.env_level <= '0;
    end else begin
      bus.env_valid <= bus.active;
      if (bus.active) begin
        bus.env_ch    <= slot_ch;
        bus.env_level <= bus.eg_level_out;
        slot_ch       <= (slot_ch == CH_BITS'(CHANNELS - 1)) ? '0
                                                             : slot_ch + CH_BITS'(1);
      end
    end
  end

  always_comb begin
    slot_pend = KEY_NONE;
    if (int'(slot_ch) < CHANNELS) slot_pend = pending[slot_ch];
  end

  always_comb begin
    bus.eg_key_on      = bus.active && (slot_pend == KEY_ON);
    bus.eg_key_release = bus.active && (slot_pend == KEY_RELEASE);
    bus.eg_key_off     = bus.active && (slot_pend == KEY_OFF);
  end

  assign bus.eg_counter_in = rd_ctx.counter;
  assign bus.eg_state_in   = rd_ctx.state;
  assign bus.eg_level_in   = rd_ctx.level;
  assign bus.slot_ch       = slot_ch;

endmodule

// File: tb/tb_wts_envelope_channel_sequencer.sv
// Scoreboard bench for the envelope channel sequencer (CHANNELS=8).
// Stimulus pushes the expected slot presentation and published level into
// queues; a monitor on the falling edge pops and compares them.
module tb_wts_envelope_channel_sequencer;
  import wts_envelope_pkg::*;

  localparam int NCH = 8;

  logic clk;
  logic nreset;

  wts_envelope_channel_sequencer_if #(.CH_BITS(3)) bus ();

  wts_envelope_channel_sequencer #(
    .CHANNELS (NCH),
    .CH_BITS  (3)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [1:0]  key;
    logic [19:0] cnt;
    logic [2:0]  st;
    logic [6:0]  lvl;
  } slot_exp_t;

  typedef struct {
    logic [2:0] ch;
    logic [6:0] lvl;
  } env_exp_t;

  slot_exp_t slot_q[$];
  env_exp_t  env_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] m_cnt [NCH];
  logic [2:0]  m_st  [NCH];
  logic [6:0]  m_lvl [NCH];
  int          m_slot;
  int          pat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: each active slot is compared against the queued expectation,
  // each env_valid strobe against the queued published level.
  always @(negedge clk) begin
    if (nreset) begin
      if (bus.active) begin
        if (slot_q.size() == 0) begin
          chk("slot_unexpected", 32'd1, 32'd0);
        end else begin
          slot_exp_t s;
          logic [1:0] akey;
          s = slot_q.pop_front();
          akey = bus.eg_key_on ? 2'd1 : bus.eg_key_release ? 2'd2 :
                 bus.eg_key_off ? 2'd3 : 2'd0;
          chk("slot_ch", bus.slot_ch, s.ch);
          chk("key_count", $countones({bus.eg_key_on, bus.eg_key_release, bus.eg_key_off}),
              (s.key != 2'd0) ? 32'd1 : 32'd0);
          chk("key_code", akey, s.key);
          chk("counter_in", bus.eg_counter_in, s.cnt);
          chk("state_in", bus.eg_state_in, s.st);
          chk("level_in", bus.eg_level_in, s.lvl);
        end
      end else begin
        chk("idle_keys", {bus.eg_key_on, bus.eg_key_release, bus.eg_key_off}, 32'd0);
      end
      if (bus.env_valid) begin
        if (env_q.size() == 0) begin
          chk("env_unexpected", 32'd1, 32'd0);
        end else begin
          env_exp_t e;
          e = env_q.pop_front();
          chk("env_ch", bus.env_ch, e.ch);
          chk("env_level", bus.env_level, e.lvl);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = '0;
      m_st[i]  = '0;
      m_lvl[i] = '0;
    end
    m_slot = 0;
  endtask

  task automatic key(input int ch, input int cmd);
    bus.key_wr  = 1'b1;
    bus.key_ch  = 3'(ch);
    bus.key_cmd = 2'(cmd);
  endtask

  task automatic run_ctx(input logic [1:0] kexp, input logic [19:0] co,
                         input logic [2:0] so, input logic [6:0] lo);
    slot_exp_t s;
    env_exp_t  e;
    bus.active         = 1'b1;
    bus.eg_counter_out = co;
    bus.eg_state_out   = so;
    bus.eg_level_out   = lo;
    s.ch  = 3'(m_slot);
    s.key = kexp;
    s.cnt = m_cnt[m_slot];
    s.st  = m_st[m_slot];
    s.lvl = m_lvl[m_slot];
    slot_q.push_back(s);
    e.ch  = 3'(m_slot);
    e.lvl = lo;
    env_q.push_back(e);
    m_cnt[m_slot] = co;
    m_st[m_slot]  = so;
    m_lvl[m_slot] = lo;
    m_slot = (m_slot + 1) % NCH;
    @(posedge clk);
    #1;
    bus.key_wr = 1'b0;
  endtask

  task automatic run(input logic [1:0] kexp);
    pat++;
    run_ctx(kexp, 20'h A0000 + 20'(pat * 37), 3'(pat % 5), 7'(pat % 65));
  endtask

  task automatic to_slot(input int s);
    while (m_slot != s) run(2'd0);
  endtask

  task automatic idle(input int n);
    bus.active = 1'b0;
    repeat (n) begin
      chk("stall_slot_ch", bus.slot_ch, 32'(m_slot));
      @(posedge clk);
      #1;
      bus.key_wr = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_slot_ch", bus.slot_ch, 32'd0);
    chk("rst_env_valid", bus.env_valid, 32'd0);
    chk("rst_env_ch", bus.env_ch, 32'd0);
    chk("rst_env_level", bus.env_level, 32'd0);
    chk("rst_counter_in", bus.eg_counter_in, 32'd0);
    chk("rst_state_in", bus.eg_state_in, 32'd0);
    chk("rst_level_in", bus.eg_level_in, 32'd0);
    chk("rst_keys", {bus.eg_key_on, bus.eg_key_release, bus.eg_key_off}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nreset             = 1'b0;
    bus.active         = 1'b1;
    bus.key_wr         = 1'b0;
    bus.key_ch         = '0;
    bus.key_cmd        = '0;
    bus.eg_counter_out = 20'h FFFFF;
    bus.eg_state_out   = 3'd4;
    bus.eg_level_out   = 7'd64;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    nreset     = 1'b1;
    bus.active = 1'b0;
    @(posedge clk);
    #1;

    // writeback through slot 3, then read it back on the next visit
    to_slot(3);
    run_ctx(2'd0, 20'h 12345, 3'd2, 7'd40);
    to_slot(3);
    run(2'd0);

    // key on for ch 2 issued while slot 6 is presented
    to_slot(6);
    key(2, 1);
    run(2'd0);
    to_slot(2);
    run(2'd1);
    to_slot(2);
    run(2'd0);

    // collision: key off targets the slot being processed
    to_slot(4);
    key(4, 3);
    run(2'd0);
    to_slot(4);
    run(2'd3);

    // last write wins
    to_slot(5);
    key(1, 1);
    run(2'd0);
    key(1, 2);
    run(2'd0);
    to_slot(1);
    run(2'd2);

    // cancel
    key(1, 1);
    run(2'd0);
    key(1, 0);
    run(2'd0);
    to_slot(1);
    run(2'd0);

    // stall at slot 7 with a command latched during the stall
    to_slot(7);
    bus.active = 1'b0;
    key(7, 1);
    idle(5);
    run(2'd1);
    run(2'd0);

    // reset in the middle of the scan with pending work
    to_slot(4);
    key(6, 3);
    run(2'd0);
    bus.active         = 1'b1;
    bus.eg_counter_out = 20'h 54321;
    bus.eg_state_out   = 3'd3;
    bus.eg_level_out   = 7'd33;
    nreset             = 1'b0;
    #2;
    chk_reset_outputs();
    env_q.delete();
    chk("rst_slot_q_empty", slot_q.size(), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    for (int i = 0; i < NCH; i++) run(2'd0);

    idle(3);
    chk("slot_q_drained", slot_q.size(), 32'd0);
    chk("env_q_drained", env_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wts_envelope_channel_sequencer.md
Name: wts_envelope_channel_sequencer

Overview:
- Time-multiplexed front/back end for the per-channel ADSR envelope generator datapath.
- Holds every channel's envelope context (20-bit rate counter, 3-bit state, 7-bit level) and scans channels round-robin.
- Latches CPU key commands as pending per-channel events and presents them as single-slot key_on/key_release/key_off pulses.
- Writes the updated context back and publishes each channel's level to the mixer.

Parameters:
- CHANNELS, 8, number of sound channels scanned (2..32).
- CH_BITS, 3, width of channel index; must satisfy 2**CH_BITS >= CHANNELS.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- active  in  1  slot enable; the scan advances and a channel is processed only in cycles with active=1
- key_wr  in  1  CPU key command strobe, one cycle
- key_ch  in  CH_BITS  channel addressed by key_wr
- key_cmd  in  2  command code: 1=key on, 2=key release, 3=key off, 0=cancel pending
- eg_key_on  out  1  key-on pulse to the envelope datapath for the current slot
- eg_key_release  out  1  key-release pulse for the current slot
- eg_key_off  out  1  key-off pulse for the current slot
- eg_counter_in  out  20  stored counter of the current slot channel
- eg_state_in  out  3  stored state of the current slot channel
- eg_level_in  out  7  stored level of the current slot channel
- eg_counter_out  in  20  updated counter returned by the datapath
- eg_state_out  in  3  updated state returned by the datapath
- eg_level_out  in  7  updated level returned by the datapath (0..64)
- slot_ch  out  CH_BITS  channel currently presented
- env_valid  out  1  one-cycle strobe: env_ch/env_level updated
- env_ch  out  CH_BITS  channel of the published level
- env_level  out  7  published level

Behaviour:
Reset (nreset=0, asynchronous):
- All per-channel contexts are cleared: counter=0, state=0 (idle), level=0.
- All pending commands are cleared.
- slot_ch=0, env_valid=0, env_ch=0, env_level=0.

Slot outputs:
- eg_*_in and eg_key_* are combinational from the slot_ch context and its pending register.
- eg_key_* are gated by active: all three are 0 when active=0.
- At most one eg_key_* is 1 in any cycle (decoded from the 2-bit pending code).

Active cycle, at the clock edge:
- The slot_ch context is written with eg_counter_out/eg_state_out/eg_level_out.
- The slot_ch pending register is cleared.
- env_valid<=1, env_ch<=slot_ch, env_level<=eg_level_out. This gives a 1-cycle latency from slot to published level.
- slot_ch advances: CHANNELS-1 wraps to 0.

Inactive cycle:
- No context write and no advance.
- env_valid<=0; env_ch and env_level hold.

Key commands:
- key_wr writes key_cmd into pending[key_ch]; the last write before the channel's slot wins.
- key_cmd=0 cancels a pending command.
- A key_ch value >= CHANNELS is ignored.
- If key_wr targets slot_ch in an active cycle, the new command is not presented in this slot; it survives the pending clear and is presented on the next visit.
- A key_wr in an inactive cycle targeting slot_ch is simply latched.

Widths and context:
- No arithmetic is done on the context beyond storage; all values are stored unmodified.
- Worst-case command-to-pulse latency is CHANNELS active cycles.

Decomposition:
- Shared package wts_envelope_pkg:
  - State encodings: ST_IDLE=0, ST_ATTACK=1, ST_DECAY=2, ST_SUSTAIN=3, ST_RELEASE=4.
  - Key command codes: KEY_NONE/ON/RELEASE/OFF.
  - Counter width 20, level width 7, full-scale level 64.
- One natural sub-module, wts_envelope_context_ram: a CHANNELS-entry, 30-bit register file with one asynchronous read port and one write port, reset to zero.
- Pending-command logic and scan pointer stay in the top.

Test Plan:
- Reset mid-scan:
  - Stimulus: assert nreset=0 at slot_ch=5 with active=1, context and pending nonzero.
  - Response: slot_ch=0, env_valid=0, every channel reads counter=0/state=0/level=0, no eg_key_* pulses afterwards.
- Key on, CHANNELS=8:
  - Stimulus: key_wr ch=2 cmd=1 while slot_ch=6, active held 1.
  - Response: eg_key_on=1 exactly in the cycle slot_ch=2 and nowhere else; next pass over ch 2 shows no pulse.
- Writeback:
  - Stimulus: in slot 3 drive eg_counter_out=0x12345, eg_state_out=2, eg_level_out=40.
  - Response: next cycle env_valid=1, env_ch=3, env_level=40; on the next visit to slot 3, eg_counter_in=0x12345, eg_state_in=2, eg_level_in=40.
- Collision:
  - Stimulus: key_wr ch=4 cmd=3 in the active cycle with slot_ch=4.
  - Response: no eg_key_off in that slot; eg_key_off=1 on the next visit to slot 4.
- Last write wins / cancel:
  - Stimulus: writes to ch 1 of cmd=1 then cmd=2 before its slot.
  - Response: only eg_key_release fires.
  - Stimulus: writes of cmd=1 then cmd=0.
  - Response: no pulse.
- Stall:
  - Stimulus: active=0 for 5 cycles at slot_ch=7 with key pending.
  - Response: slot_ch stays 7, no eg_key_*, env_valid=0, context unchanged; first active cycle processes ch 7, then slot_ch wraps to 0.
